// File: rtl/ps2_kbd_receiver_pkg.sv
// rtl/ps2_kbd_receiver_pkg.sv - shared PS/2 frame constants and frame check
// Purpose: frame geometry constants and the validity check for a received
//          PS/2 frame, shared by the receiver and its FIFO.
// Contents: PS2_FRAME_BITS, PS2_DATA_BITS, ps2_frame_ok().
package ps2_kbd_receiver_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  // buffered holds start (bit 0), d0..d7 (bits 8:1) and parity (bit 9);
  // stop is the sample arriving on the 11th falling edge.
  function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-2:0] buffered,
                                        input logic stop);
    return ~buffered[0] & stop & (^buffered[PS2_FRAME_BITS-2:1]);
  endfunction

endpackage

// File: rtl/ps2_kbd_fifo.sv
// rtl/ps2_kbd_fifo.sv - received scan-code FIFO with sticky overflow flag
// Purpose: circular buffer of received bytes; one slot is kept empty so
//          full and empty can be told apart from the pointers alone.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   wr_en, wr_data  push a validated byte
//   pop             advance the read pointer (ignored when empty)
//   rd_data         entry at the read pointer
//   not_empty       read pointer differs from write pointer
//   overflow        sticky: a push arrived while full
module ps2_kbd_fifo
  import ps2_kbd_receiver_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [PS2_DATA_BITS-1:0] wr_data,
  input  logic                     pop,
  output logic [PS2_DATA_BITS-1:0] rd_data,
  output logic                     not_empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [PS2_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic                     full;
  logic                     do_pop;

  // Full is judged on the pointers before any pop in the same cycle.
  assign full      = (wr_ptr + AW'(1)) == rd_ptr;
  assign not_empty = rd_ptr != wr_ptr;
  assign do_pop    = pop & not_empty;
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en && !full && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
        end
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_receiver.sv
// rtl/ps2_kbd_receiver.sv - PS/2 keyboard frame receiver with byte FIFO
// Purpose: synchronises the keyboard lines, shifts in 11-bit frames on
//          ps2_clk falling edges, checks start/parity/stop and queues good
//          bytes. Receive-only.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ps2_clk, ps2_data   asynchronous keyboard lines
//   nextdata_n          active-low, level-sensitive pop request
//   data                byte at FIFO head (valid while ready)
//   ready               FIFO non-empty
//   overflow            sticky: a good byte was dropped on a full FIFO
module ps2_kbd_receiver
  import ps2_kbd_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     nextdata_n,
  output logic [PS2_DATA_BITS-1:0] data,
  output logic                     ready,
  output logic                     overflow
);

  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0]    clk_sync;
  logic [SYNC_STAGES-1:0]    data_sync;
  logic                      clk_fall;
  logic                      sample;
  logic [3:0]                bit_cnt;
  logic [PS2_FRAME_BITS-2:0] shift_buf;
  logic                      frame_done;
  logic                      wr_en;

  // Stages reset to 1 so leaving reset on an idle bus creates no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Data is taken from the stage of the same age as the newer clock sample.
  assign clk_fall = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  assign sample   = data_sync[SYNC_STAGES-2];

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_buf <= '0;
    end else if (clk_fall) begin
      if (bit_cnt == LAST_BIT) begin
        bit_cnt <= '0;
      end else begin
        shift_buf[bit_cnt] <= sample;
        bit_cnt            <= bit_cnt + 4'd1;
      end
    end
  end

  assign frame_done = clk_fall & (bit_cnt == LAST_BIT);
  assign wr_en      = frame_done & ps2_frame_ok(shift_buf, sample);

  ps2_kbd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (shift_buf[PS2_DATA_BITS:1]),
    .pop      (~nextdata_n),
    .rd_data  (data),
    .not_empty(ready),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_ps2_kbd_receiver.sv
// tb/tb_ps2_kbd_receiver.sv - directed self-checking bench for ps2_kbd_receiver
module tb_ps2_kbd_receiver;

  localparam time CLK_HALF = 5ns;
  localparam time PS2_HALF = 60ns;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  ps2_kbd_receiver #(
    .FIFO_DEPTH (8),
    .SYNC_STAGES(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow)
  );

  always #CLK_HALF clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Keyboard model: drives nbits of a frame LSB first, data changing while
  // ps2_clk is high; lines are left idle-high afterwards.
  task automatic kbd_sendbits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      #PS2_HALF;
      ps2_clk = 1'b0;
      #PS2_HALF;
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic kbd_sendframe(input logic [10:0] frame);
    kbd_sendbits(frame, 11);
    #(4 * PS2_HALF);
  endtask

  task automatic kbd_sendcode(input logic [7:0] code);
    kbd_sendframe({1'b1, ~^code, code, 1'b0});
  endtask

  // One-cycle pop: nextdata_n low across exactly one rising edge.
  task automatic pop_one();
    @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] expected);
    @(negedge clk);
    check({tag, "_ready"}, {7'd0, ready}, 8'h01);
    check({tag, "_data"}, data, expected);
    pop_one();
  endtask

  initial begin
    logic [7:0] seq [5];
    logic [7:0] code;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {7'd0, ready}, 8'h00);
    check("reset_overflow", {7'd0, overflow}, 8'h00);

    // Single byte, then a break sequence read in order.
    kbd_sendcode(8'h1C);
    expect_byte("t1_1c", 8'h1C);
    check("t1_empty", {7'd0, ready}, 8'h00);
    kbd_sendcode(8'hF0);
    kbd_sendcode(8'h1C);
    expect_byte("t1_f0", 8'hF0);
    expect_byte("t1_1c_b", 8'h1C);
    check("t1_empty_b", {7'd0, ready}, 8'h00);

    // Five queued bytes without popping.
    seq = '{8'h1B, 8'h1B, 8'h1B, 8'hF0, 8'h1B};
    for (int i = 0; i < 5; i++) kbd_sendcode(seq[i]);
    for (int i = 0; i < 5; i++) expect_byte($sformatf("t2_pop%0d", i), seq[i]);
    @(negedge clk);
    check("t2_empty", {7'd0, ready}, 8'h00);
    check("t2_overflow", {7'd0, overflow}, 8'h00);

    // Bad parity, then bad stop: both dropped silently.
    kbd_sendframe({1'b1, ^8'h1C, 8'h1C, 1'b0});
    @(negedge clk);
    check("t3_badpar_ready", {7'd0, ready}, 8'h00);
    kbd_sendframe({1'b0, ~^8'h1C, 8'h1C, 1'b0});
    @(negedge clk);
    check("t3_badstop_ready", {7'd0, ready}, 8'h00);
    kbd_sendcode(8'h1B);
    expect_byte("t3_1b", 8'h1B);

    // Fill past capacity: seven fit, the eighth sets overflow.
    for (int i = 1; i <= 7; i++) kbd_sendcode(8'(i));
    @(negedge clk);
    check("t4_ovf_before", {7'd0, overflow}, 8'h00);
    kbd_sendcode(8'h08);
    @(negedge clk);
    check("t4_ovf_after", {7'd0, overflow}, 8'h01);
    for (int i = 1; i <= 7; i++) expect_byte($sformatf("t4_pop%0d", i), 8'(i));
    @(negedge clk);
    check("t4_empty", {7'd0, ready}, 8'h00);
    check("t4_ovf_sticky", {7'd0, overflow}, 8'h01);

    // Reset in the middle of a frame (with one byte queued).
    kbd_sendcode(8'h42);
    code = 8'h55;
    kbd_sendbits({1'b1, ~^code, code, 1'b0}, 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready", {7'd0, ready}, 8'h00);
    check("t5_overflow", {7'd0, overflow}, 8'h00);
    kbd_sendcode(8'h1C);
    expect_byte("t5_1c", 8'h1C);

    // Level-sensitive pop held for three cycles with two bytes queued.
    kbd_sendcode(8'h11);
    kbd_sendcode(8'h22);
    @(negedge clk);
    check("t6_head", data, 8'h11);
    nextdata_n = 1'b0;
    @(negedge clk);
    check("t6_ready1", {7'd0, ready}, 8'h01);
    check("t6_second", data, 8'h22);
    @(negedge clk);
    check("t6_ready2", {7'd0, ready}, 8'h00);
    @(negedge clk);
    check("t6_ready3", {7'd0, ready}, 8'h00);
    nextdata_n = 1'b1;
    kbd_sendcode(8'h33);
    expect_byte("t6_after", 8'h33);
    @(negedge clk);
    check("t6_final_empty", {7'd0, ready}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_receiver.md
Name: ps2_kbd_receiver

Overview:
- Receives PS/2 keyboard scan-code frames on the ps2_clk/ps2_data lines, validates them, and queues the received bytes in a small FIFO.
- The host side reads bytes with a ready/nextdata_n handshake.
- Sits between the keyboard pins and the scan-code decoder or host logic; receive-only, never drives the PS/2 lines.

Parameters:
- FIFO_DEPTH, 8, FIFO entries (power of 2, ≥2); usable capacity FIFO_DEPTH-1.
- SYNC_STAGES, 3, flip-flop stages synchronising ps2_clk and ps2_data into clk domain (≥2).

Ports:
- clk  in  1  system clock, much faster than ps2_clk (≥ 8x).
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  PS/2 clock from keyboard, asynchronous.
- ps2_data  in  1  PS/2 data from keyboard, asynchronous.
- nextdata_n  in  1  active-low pop request.
- data  out  8  byte at FIFO head (valid when ready=1).
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky: a valid byte was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at posedge clk): bit counter=0, shift buffer=0, read and write pointers=0, overflow=0, ready=0. Synchroniser stages are cleared to 1 (idle bus).
- Reset mid-frame discards the partial frame. Reset overrides every other event in the same cycle.
- Synchronisation: ps2_clk and ps2_data each pass through SYNC_STAGES flops.
- A falling edge is detected when the last two stages of ps2_clk are 1 then 0. It yields one sampling cycle.
- Frame format: 11 bits, one per falling edge:
  - start=0
  - d0..d7, LSB first
  - odd parity
  - stop=1
- Bit counter 0..10 stores each sample into a 10-bit buffer on sampling cycles.
- On the 11th sample (counter==10):
  - Validity check: start==0, stop (current sample)==1, XOR of d0..d7 and parity ==1.
  - Valid and FIFO not full: write d7..d0 at write pointer; write pointer +1 (wraps modulo FIFO_DEPTH).
  - Valid and FIFO full (write pointer+1 == read pointer): byte dropped; overflow set to 1 and held until reset.
  - Invalid: frame silently dropped; FIFO and overflow unchanged.
  - Counter returns to 0 in every case.
- Latency: ready rises on the clk edge after the write cycle. data = FIFO entry at read pointer, combinational from the registered pointer.
- ready = (read pointer != write pointer).
- Pop: at posedge clk with ready=1 and nextdata_n=0, read pointer +1 (wraps).
  - Level-sensitive: each cycle nextdata_n stays low with ready=1 pops one more byte.
  - nextdata_n is ignored while ready=0.
- Simultaneous pop and write in one cycle are both performed; full is evaluated before the pop.
- No inter-bit timeout; a stalled frame completes with subsequent edges.

Decomposition:
- Shared package holds constants PS2_FRAME_BITS=11 and PS2_DATA_BITS=8.
- One natural sub-module: ps2_kbd_fifo (pointers, storage, full/empty, overflow).
- Bench-side behavioural model ps2_keyboard_model (non-synthesisable) drives ps2_clk/ps2_data and provides task kbd_sendcode(code).
  - Idle lines are high.
  - Sends start, 8 data bits LSB first, odd parity, stop.
  - Data changes while ps2_clk is high.
  - ps2_clk half-period is a parameter, default 60 ns.
  - The task returns after the stop bit.

Test Plan:
- Send 0x1C with the bench reading whenever ready=1 → ready pulses, data=0x1C. Then send 0xF0, 0x1C → reads 0xF0, 0x1C in order; ready=0 afterwards.
- Send 0x1B, 0x1B, 0x1B, 0xF0, 0x1B with nextdata_n=1 → ready=1, data=0x1B. Pop five times → 0x1B, 0x1B, 0x1B, 0xF0, 0x1B; then ready=0; overflow=0.
- Frame 0x1C with wrong parity (or stop=0) → ready stays 0 and FIFO unchanged. Next valid 0x1B → data=0x1B.
- Send 8 distinct bytes 0x01..0x08 without popping → after the 8th, overflow=1. Pops return 0x01..0x07 only; overflow stays 1 until rst.
- Assert rst after 5 bits of a frame → ready=0, overflow=0. A fresh 0x1C frame afterwards → data=0x1C.
- Hold nextdata_n low for 3 cycles with 2 bytes queued → both popped; ready=0 from the cycle after the second pop; the extra cycle has no effect.
